// File: rtl/rv_decode_stage_pkg.sv
// Shared RV32I decode definitions: opcode classes, op-bus field layout and the
// decoded-instruction record carried through the skid buffer.
package rv_decode_stage_pkg;

   localparam int unsigned XLEN = 32;

   // Op bus layout {funct7, funct3, opcode}
   localparam int unsigned F7BUS_MSB = 16;
   localparam int unsigned F7BUS_LSB = 10;
   localparam int unsigned F3BUS_MSB = 9;
   localparam int unsigned F3BUS_LSB = 7;
   localparam int unsigned OPBUS_MSB = 6;
   localparam int unsigned OPBUS_LSB = 0;

   typedef enum logic [6:0] {
      OP_LOAD   = 7'b0000011,
      OP_ITYPE  = 7'b0010011,
      OP_AUIPC  = 7'b0010111,
      OP_STYPE  = 7'b0100011,
      OP_RTYPE  = 7'b0110011,
      OP_LUI    = 7'b0110111,
      OP_BTYPE  = 7'b1100011,
      OP_JALR   = 7'b1100111,
      OP_UJTYPE = 7'b1101111
   } opcode_e;

   typedef struct packed {
      logic [F7BUS_MSB:0] op;
      logic [XLEN-1:0]    imm;
      logic [4:0]         rs1;
      logic [4:0]         rs2;
      logic [4:0]         rd;
      logic [XLEN-1:0]    pc;
      logic               use_imm;
      logic               illegal;
   } dec_t;

   function automatic logic [F7BUS_MSB:0] pack_op(input logic [6:0] f7,
                                                  input logic [2:0] f3,
                                                  input logic [6:0] opc);
      return {f7, f3, opc};
   endfunction

endpackage

// File: rtl/rv_decode_stage_imm_gen.sv
// Combinational RV32I field decode: op bus, immediate, operand select,
// legality and class-masked register indices.
module rv_imm_gen
   import rv_decode_stage_pkg::*;
(
   input  logic [XLEN-1:0]    i_instr,
   output logic [F7BUS_MSB:0] o_op,
   output logic [XLEN-1:0]    o_imm,
   output logic [4:0]         o_rs1,
   output logic [4:0]         o_rs2,
   output logic [4:0]         o_rd,
   output logic               o_use_imm,
   output logic               o_illegal
);

   logic [6:0]      w_opc;
   logic [2:0]      w_f3;
   logic [6:0]      w_f7;
   logic            w_shift;
   logic [XLEN-1:0] w_imm_i, w_imm_s, w_imm_b, w_imm_u, w_imm_j;

   assign w_opc   = i_instr[6:0];
   assign w_f3    = i_instr[14:12];
   assign w_f7    = i_instr[31:25];
   assign w_shift = (w_f3 == 3'b001) || (w_f3 == 3'b101);
   assign w_imm_i = {{20{i_instr[31]}}, i_instr[31:20]};
   assign w_imm_s = {{20{i_instr[31]}}, i_instr[31:25], i_instr[11:7]};
   assign w_imm_b = {{19{i_instr[31]}}, i_instr[31], i_instr[7], i_instr[30:25], i_instr[11:8], 1'b0};
   assign w_imm_u = {i_instr[31:12], 12'b0};
   assign w_imm_j = {{11{i_instr[31]}}, i_instr[31], i_instr[19:12], i_instr[20], i_instr[30:21], 1'b0};

   always_comb begin
      o_op      = pack_op(7'b0, 3'b0, w_opc);
      o_imm     = '0;
      o_rs1     = i_instr[19:15];
      o_rs2     = '0;
      o_rd      = i_instr[11:7];
      o_use_imm = 1'b1;
      o_illegal = 1'b0;
      case (w_opc)
         OP_RTYPE: begin
            o_op      = pack_op(w_f7, w_f3, w_opc);
            o_rs2     = i_instr[24:20];
            o_use_imm = 1'b0;
            o_illegal = !((w_f7 == 7'h00) ||
                          ((w_f7 == 7'h20) && ((w_f3 == 3'b000) || (w_f3 == 3'b101))));
         end
         OP_ITYPE: begin
            if (w_shift) begin
               o_op      = pack_op(w_f7, w_f3, w_opc);
               o_imm     = {27'b0, i_instr[24:20]};
               o_illegal = !((w_f7 == 7'h00) || ((w_f3 == 3'b101) && (w_f7 == 7'h20)));
            end else begin
               o_op  = pack_op(7'b0, w_f3, w_opc);
               o_imm = w_imm_i;
            end
         end
         OP_LOAD: begin
            o_op      = pack_op(7'b0, w_f3, w_opc);
            o_imm     = w_imm_i;
            o_illegal = (w_f3 == 3'b011) || (w_f3 == 3'b110) || (w_f3 == 3'b111);
         end
         OP_STYPE: begin
            o_op      = pack_op(7'b0, w_f3, w_opc);
            o_imm     = w_imm_s;
            o_rs2     = i_instr[24:20];
            o_rd      = '0;
            o_illegal = (w_f3 > 3'b010);
         end
         OP_BTYPE: begin
            o_op      = pack_op(7'b0, w_f3, w_opc);
            o_imm     = w_imm_b;
            o_rs2     = i_instr[24:20];
            o_rd      = '0;
            o_use_imm = 1'b0;
            o_illegal = (w_f3 == 3'b010) || (w_f3 == 3'b011);
         end
         OP_JALR: begin
            o_op      = pack_op(7'b0, w_f3, w_opc);
            o_imm     = w_imm_i;
            o_illegal = (w_f3 != 3'b000);
         end
         OP_UJTYPE: begin
            o_imm = w_imm_j;
            o_rs1 = '0;
         end
         OP_LUI, OP_AUIPC: begin
            o_imm = w_imm_u;
            o_rs1 = '0;
         end
         default: o_illegal = 1'b1;
      endcase
      if (i_instr[1:0] != 2'b11) o_illegal = 1'b1;
   end

endmodule

// File: rtl/rv_decode_stage.sv
// Registered RV32I decode stage: combinational field decode feeding a
// two-entry skid buffer so neither handshake has a combinational path.
module rv_decode_stage
   import rv_decode_stage_pkg::*;
(
   input  logic                clk,
   input  logic                rst,
   input  logic                flush,
   input  logic                in_valid,
   output logic                in_ready,
   input  logic [XLEN-1:0]     in_instr,
   input  logic [XLEN-1:0]     in_pc,
   output logic                out_valid,
   input  logic                out_ready,
   output logic [F7BUS_MSB:0]  out_op,
   output logic [XLEN-1:0]     out_imm,
   output logic [4:0]          out_rs1,
   output logic [4:0]          out_rs2,
   output logic [4:0]          out_rd,
   output logic [XLEN-1:0]     out_pc,
   output logic                out_use_imm,
   output logic                out_illegal
);

   dec_t r_main, r_skid, w_dec;
   logic r_main_valid, r_skid_valid;
   logic w_accept, w_pop;

   rv_imm_gen u_imm_gen (
      .i_instr   (in_instr),
      .o_op      (w_dec.op),
      .o_imm     (w_dec.imm),
      .o_rs1     (w_dec.rs1),
      .o_rs2     (w_dec.rs2),
      .o_rd      (w_dec.rd),
      .o_use_imm (w_dec.use_imm),
      .o_illegal (w_dec.illegal)
   );
   assign w_dec.pc = in_pc;

   assign w_accept = in_valid && in_ready;
   assign w_pop    = r_main_valid && out_ready;

   // Skid can only fill while main is stalled, so a pop with skid full never sees an accept
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_main       <= '0;
         r_skid       <= '0;
         r_main_valid <= 1'b0;
         r_skid_valid <= 1'b0;
      end else if (flush) begin
         r_main_valid <= 1'b0;
         r_skid_valid <= 1'b0;
      end else if (w_pop) begin
         if (r_skid_valid) begin
            r_main       <= r_skid;
            r_skid_valid <= 1'b0;
         end else if (w_accept) begin
            r_main <= w_dec;
         end else begin
            r_main_valid <= 1'b0;
         end
      end else if (w_accept) begin
         if (!r_main_valid) begin
            r_main       <= w_dec;
            r_main_valid <= 1'b1;
         end else begin
            r_skid       <= w_dec;
            r_skid_valid <= 1'b1;
         end
      end
   end

   assign in_ready    = !r_skid_valid;
   assign out_valid   = r_main_valid;
   assign out_op      = r_main.op;
   assign out_imm     = r_main.imm;
   assign out_rs1     = r_main.rs1;
   assign out_rs2     = r_main.rs2;
   assign out_rd      = r_main.rd;
   assign out_pc      = r_main.pc;
   assign out_use_imm = r_main.use_imm;
   assign out_illegal = r_main.illegal;

endmodule

// File: tb/tb_rv_decode_stage.sv
// Scoreboard bench for rv_decode_stage: accepted instructions are decoded by a
// reference model into a queue; a monitor pops and compares each emitted result.
module tb_rv_decode_stage;
   import rv_decode_stage_pkg::*;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        flush = 1'b0;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [31:0] in_instr = '0;
   logic [31:0] in_pc = '0;
   logic        out_valid;
   logic        out_ready = 1'b0;
   logic [16:0] out_op;
   logic [31:0] out_imm;
   logic [4:0]  out_rs1, out_rs2, out_rd;
   logic [31:0] out_pc;
   logic        out_use_imm, out_illegal;

   int   checks = 0;
   int   errors = 0;
   dec_t exp_q[$];

   rv_decode_stage dut (
      .clk(clk), .rst(rst), .flush(flush),
      .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr), .in_pc(in_pc),
      .out_valid(out_valid), .out_ready(out_ready), .out_op(out_op), .out_imm(out_imm),
      .out_rs1(out_rs1), .out_rs2(out_rs2), .out_rd(out_rd), .out_pc(out_pc),
      .out_use_imm(out_use_imm), .out_illegal(out_illegal)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, req, $time);
      end
   endtask

   task automatic chk_dec(input string name, input dec_t act, input dec_t req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got op=%h imm=%h rs1=%0d rs2=%0d rd=%0d pc=%h ui=%b il=%b expected op=%h imm=%h rs1=%0d rs2=%0d rd=%0d pc=%h ui=%b il=%b",
                  name, act.op, act.imm, act.rs1, act.rs2, act.rd, act.pc, act.use_imm, act.illegal,
                  req.op, req.imm, req.rs1, req.rs2, req.rd, req.pc, req.use_imm, req.illegal);
      end
   endtask

   function automatic dec_t dut_out();
      dec_t d;
      d.op = out_op; d.imm = out_imm; d.rs1 = out_rs1; d.rs2 = out_rs2; d.rd = out_rd;
      d.pc = out_pc; d.use_imm = out_use_imm; d.illegal = out_illegal;
      return d;
   endfunction

   // Reference decode: immediates rebuilt numerically from their scattered fields
   function automatic dec_t model(input logic [31:0] ins, input logic [31:0] pc);
      dec_t       d;
      logic [6:0] opc = ins[6:0];
      logic [2:0] f3  = ins[14:12];
      logic [6:0] f7  = ins[31:25];
      int         v   = 0;
      bit         f3_used = 1'b1;
      bit         f7_used = 1'b0;
      d = '0;
      d.pc = pc; d.rs1 = ins[19:15]; d.rd = ins[11:7]; d.use_imm = 1'b1;
      case (opc)
         7'h33: begin
            f7_used = 1'b1; d.rs2 = ins[24:20]; d.use_imm = 1'b0;
            d.illegal = !(f7 == 0 || (f7 == 7'h20 && (f3 == 0 || f3 == 5)));
         end
         7'h13: begin
            if (f3 == 1 || f3 == 5) begin
               f7_used = 1'b1; v = int'(ins[24:20]);
               d.illegal = !(f7 == 0 || (f3 == 5 && f7 == 7'h20));
            end else begin
               v = int'(ins[31:20]); if (ins[31]) v -= 4096;
            end
         end
         7'h03: begin
            v = int'(ins[31:20]); if (ins[31]) v -= 4096;
            d.illegal = (f3 == 3 || f3 == 6 || f3 == 7);
         end
         7'h67: begin
            v = int'(ins[31:20]); if (ins[31]) v -= 4096;
            d.illegal = (f3 != 0);
         end
         7'h23: begin
            v = int'({ins[31:25], ins[11:7]}); if (ins[31]) v -= 4096;
            d.rs2 = ins[24:20]; d.rd = 0; d.illegal = (f3 > 2);
         end
         7'h63: begin
            v = int'({ins[31], ins[7], ins[30:25], ins[11:8]}) * 2; if (ins[31]) v -= 8192;
            d.rs2 = ins[24:20]; d.rd = 0; d.use_imm = 1'b0; d.illegal = (f3 == 2 || f3 == 3);
         end
         7'h6F: begin
            f3_used = 1'b0; d.rs1 = 0;
            v = int'({ins[31], ins[19:12], ins[20], ins[30:21]}) * 2; if (ins[31]) v -= 2097152;
         end
         7'h37, 7'h17: begin
            f3_used = 1'b0; d.rs1 = 0; v = int'(ins & 32'hFFFF_F000);
         end
         default: begin
            f3_used = 1'b0; d.illegal = 1'b1;
         end
      endcase
      d.imm = v;
      d.op  = {(f7_used ? f7 : 7'd0), (f3_used ? f3 : 3'd0), opc};
      if (ins[1:0] != 2'b11) d.illegal = 1'b1;
      return d;
   endfunction

   function automatic logic [31:0] rand_instr();
      logic [6:0]  ops[9] = '{7'h33, 7'h13, 7'h03, 7'h23, 7'h63, 7'h6F, 7'h67, 7'h37, 7'h17};
      logic [31:0] r = $urandom;
      if ($urandom_range(0, 4) != 0) r[6:0] = ops[$urandom_range(0, 8)];
      if ($urandom_range(0, 1) != 0) r[31:25] = ($urandom_range(0, 1) != 0) ? 7'h20 : 7'h00;
      return r;
   endfunction

   // Acceptance tracker: occupancy checks, then push or flush the scoreboard
   always @(negedge clk) begin
      if (rst) begin
         exp_q.delete();
      end else begin
         chk("out_valid_vs_occupancy", {31'b0, out_valid}, {31'b0, exp_q.size() > 0});
         chk("in_ready_vs_occupancy", {31'b0, in_ready}, {31'b0, exp_q.size() < 2});
         if (flush) exp_q.delete();
         else if (in_valid && in_ready) exp_q.push_back(model(in_instr, in_pc));
      end
   end

   // Monitor: every downstream transfer must match the oldest outstanding entry
   always @(negedge clk) begin
      #1;
      if (!rst && !flush && out_valid && out_ready) begin
         if (exp_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL emit_underflow: got unexpected op=%h pc=%h expected no output", out_op, out_pc);
         end else begin
            chk_dec("decode", dut_out(), exp_q.pop_front());
         end
      end
   end

   task automatic cyc(input bit v, input logic [31:0] ins, input bit ordy, input bit fl);
      @(posedge clk); #1;
      in_valid = v; in_instr = ins; in_pc = $urandom & 32'hFFFF_FFFC; out_ready = ordy; flush = fl;
   endtask

   task automatic check_reset_zero(input string name);
      chk({name, "_out_valid"}, {31'b0, out_valid}, 32'd0);
      chk({name, "_in_ready"}, {31'b0, in_ready}, 32'd1);
      chk_dec({name, "_fields"}, dut_out(), '0);
   endtask

   logic [31:0] directed[6] = '{32'h002081B3, 32'h402081B3, 32'hFFF00093,
                                32'h0020A423, 32'hFE208EE3, 32'hFFFFFFFF};

   initial begin
      #1 rst = 1'b1;
      #2 check_reset_zero("reset_initial");
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;

      foreach (directed[i]) cyc(1'b1, directed[i], 1'b1, 1'b0);
      cyc(1'b0, '0, 1'b1, 1'b0);
      cyc(1'b0, '0, 1'b1, 1'b0);

      // Stall 3 cycles with back-to-back valid, then release
      for (int unsigned i = 0; i < 3; i++) cyc(1'b1, rand_instr(), 1'b0, 1'b0);
      for (int unsigned i = 0; i < 3; i++) cyc(1'b0, '0, 1'b1, 1'b0);

      // Flush with both entries full and out_ready high
      cyc(1'b1, rand_instr(), 1'b0, 1'b0);
      cyc(1'b1, rand_instr(), 1'b0, 1'b0);
      cyc(1'b1, rand_instr(), 1'b1, 1'b1);
      cyc(1'b0, '0, 1'b1, 1'b0);
      // Flush with main full and a concurrent accept
      cyc(1'b1, rand_instr(), 1'b0, 1'b0);
      cyc(1'b1, rand_instr(), 1'b1, 1'b1);
      cyc(1'b0, '0, 1'b1, 1'b0);
      cyc(1'b0, '0, 1'b1, 1'b0);

      for (int unsigned i = 0; i < 600; i++)
         cyc($urandom_range(0, 3) != 0, rand_instr(), $urandom_range(0, 9) < 7, $urandom_range(0, 32) == 0);

      // Asynchronous reset mid-stream, away from any clock edge
      cyc(1'b1, rand_instr(), 1'b0, 1'b0);
      cyc(1'b1, rand_instr(), 1'b0, 1'b0);
      #2 rst = 1'b1;
      #1 check_reset_zero("reset_async");
      @(posedge clk); #1;
      in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1;
      @(posedge clk); #1 rst = 1'b0;

      for (int unsigned i = 0; i < 300; i++)
         cyc($urandom_range(0, 3) != 0, rand_instr(), $urandom_range(0, 9) < 6, $urandom_range(0, 40) == 0);

      cyc(1'b0, '0, 1'b1, 1'b0);
      for (int unsigned i = 0; i < 10 && exp_q.size() != 0; i++) @(negedge clk);
      @(negedge clk); #2;
      chk("drain_remaining", exp_q.size(), 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
